// File: rtl/alu_issue_ctrl.sv
// Operand-issue and write-back stage for an external 8-bit ALU: small register
// file, valid/ready instruction intake, registered ALU operands, one-cycle write-back.
module alu_issue_ctrl #(
  parameter int DW   = 8,
  parameter int RA_W = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic            instr_li,
  input  logic [2:0]      instr_op,
  input  logic [RA_W-1:0] instr_rd,
  input  logic [RA_W-1:0] instr_rs,
  input  logic [RA_W-1:0] instr_rt,
  input  logic [DW-1:0]   instr_imm,
  output logic [DW-1:0]   alu_a,
  output logic [DW-1:0]   alu_b,
  output logic [2:0]      alu_op,
  input  logic [DW-1:0]   alu_res,
  input  logic            alu_z,
  output logic            done,
  output logic            illegal,
  output logic [DW-1:0]   result,
  output logic            z_flag,
  input  logic [RA_W-1:0] dbg_addr,
  output logic [DW-1:0]   dbg_data
);

  localparam int          NREG    = 2 ** RA_W;
  localparam logic [2:0]  OP_LAST = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_e;

  state_e            r_state;
  logic [DW-1:0]     r_rf [NREG];
  logic [RA_W-1:0]   r_rd;
  logic              r_z_pend;

  assign dbg_data = r_rf[dbg_addr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      // NOTE: the register file is reset entry by entry because software relies
      // on every register reading 0 after reset; this keeps it out of RAM macros.
      for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
      r_rd        <= '0;
      r_z_pend    <= 1'b0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op      <= 3'b000;
      result      <= '0;
      z_flag      <= 1'b0;
      done        <= 1'b0;
      illegal     <= 1'b0;
      instr_ready <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments only, so every branch sees the register
      // file and operands as they were at the start of the cycle.
      unique case (r_state)
        S_IDLE: begin
          if (instr_valid) begin
            r_rd        <= instr_rd;
            instr_ready <= 1'b0;
            if (instr_li) begin
              result   <= instr_imm;
              r_z_pend <= (instr_imm == '0);
              illegal  <= 1'b0;
              done     <= 1'b1;
              r_state  <= S_WB;
            end else if (instr_op > OP_LAST) begin
              result   <= '0;
              illegal  <= 1'b1;
              done     <= 1'b1;
              r_state  <= S_WB;
            end else begin
              // Operands are sampled here, so rd == rs/rt uses the old value.
              alu_a    <= r_rf[instr_rs];
              alu_b    <= r_rf[instr_rt];
              alu_op   <= instr_op;
              illegal  <= 1'b0;
              r_state  <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          result   <= alu_res;
          r_z_pend <= alu_z;
          done     <= 1'b1;
          r_state  <= S_WB;
        end
        S_WB: begin
          if (!illegal) begin
            r_rf[r_rd] <= result;
            z_flag     <= r_z_pend;
          end
          done        <= 1'b0;
          instr_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: begin
          done        <= 1'b0;
          instr_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed scenarios plus random
// instructions compared against an array-based model of the register file.
module tb_alu_issue_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       instr_valid;
  logic       instr_ready;
  logic       instr_li;
  logic [2:0] instr_op;
  logic [1:0] instr_rd, instr_rs, instr_rt;
  logic [7:0] instr_imm;
  logic [7:0] alu_a, alu_b;
  logic [2:0] alu_op;
  logic [7:0] alu_res;
  logic       alu_z;
  logic       done, illegal;
  logic [7:0] result;
  logic       z_flag;
  logic [1:0] dbg_addr;
  logic [7:0] dbg_data;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] m_rf [4];
  logic       m_z;

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_ref(input logic [2:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ~a;
      default: return 8'h00;
    endcase
  endfunction

  // The ALU itself lives outside the DUT; model it here.
  assign alu_res = alu_ref(alu_op, alu_a, alu_b);
  assign alu_z   = (alu_res == 8'h00);

  alu_issue_ctrl #(.DW(8), .RA_W(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_li(instr_li), .instr_op(instr_op),
    .instr_rd(instr_rd), .instr_rs(instr_rs), .instr_rt(instr_rt),
    .instr_imm(instr_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_res(alu_res), .alu_z(alu_z),
    .done(done), .illegal(illegal), .result(result), .z_flag(z_flag),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i);
      #1;
      n_tests++;
      if (dbg_data !== m_rf[i]) begin
        n_fail++;
        $display("FAIL %s r%0d: got %h expected %h", tag, i, dbg_data, m_rf[i]);
      end
    end
  endtask

  // Issue one instruction from IDLE (called at posedge+1); returns at posedge+1 in IDLE.
  task automatic run_instr(input string tag, input bit li, input logic [2:0] op,
                           input logic [1:0] rd, input logic [1:0] rs,
                           input logic [1:0] rt, input logic [7:0] imm, input bit hold);
    logic [7:0] ea, eb, eres;
    bit         eill;
    int         lat, cyc;
    eill = !li && (op >= 3'd6);
    ea   = m_rf[rs];
    eb   = m_rf[rt];
    eres = li ? imm : (eill ? 8'h00 : alu_ref(op, ea, eb));
    lat  = (li || eill) ? 1 : 2;

    n_tests++;
    if (instr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s ready_idle: got %b expected 1", tag, instr_ready);
    end
    instr_valid = 1'b1; instr_li = li; instr_op = op;
    instr_rd = rd; instr_rs = rs; instr_rt = rt; instr_imm = imm;
    tick;
    if (!hold) instr_valid = 1'b0;

    n_tests++;
    if (instr_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s ready_busy: got %b expected 0", tag, instr_ready);
    end
    if (lat == 2) begin
      n_tests++;
      if (alu_a !== ea || alu_b !== eb || alu_op !== op) begin
        n_fail++;
        $display("FAIL %s operands: got a=%h b=%h op=%0d expected a=%h b=%h op=%0d",
                 tag, alu_a, alu_b, alu_op, ea, eb, op);
      end
    end

    cyc = 1;
    while (done !== 1'b1 && cyc < 6) begin
      tick;
      cyc++;
    end
    n_tests++;
    if (done !== 1'b1 || cyc != lat) begin
      n_fail++;
      $display("FAIL %s latency: got done=%b after %0d cycles expected done=1 after %0d",
               tag, done, cyc, lat);
    end
    n_tests++;
    if (result !== eres || illegal !== eill || instr_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s wb: got result=%h illegal=%b ready=%b expected result=%h illegal=%b ready=0",
               tag, result, illegal, instr_ready, eres, eill);
    end
    if (!eill) begin
      m_rf[rd] = eres;
      m_z      = (eres == 8'h00);
    end

    tick;
    instr_valid = 1'b0;
    n_tests++;
    if (done !== 1'b0 || instr_ready !== 1'b1 || z_flag !== m_z) begin
      n_fail++;
      $display("FAIL %s post_wb: got done=%b ready=%b z=%b expected done=0 ready=1 z=%b",
               tag, done, instr_ready, z_flag, m_z);
    end
    dbg_addr = rd;
    #1;
    n_tests++;
    if (dbg_data !== m_rf[rd]) begin
      n_fail++;
      $display("FAIL %s dbg_rd: got %h expected %h", tag, dbg_data, m_rf[rd]);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    instr_valid = 1'b0; instr_li = 1'b0; instr_op = 3'd0;
    instr_rd = 2'd0; instr_rs = 2'd0; instr_rt = 2'd0; instr_imm = 8'h00;
    dbg_addr = 2'd0;
    for (int i = 0; i < 4; i++) m_rf[i] = 8'h00;
    m_z = 1'b0;
    #12;
    n_tests++;
    if (instr_ready !== 1'b1 || done !== 1'b0 || illegal !== 1'b0 || result !== 8'h00 ||
        z_flag !== 1'b0 || alu_a !== 8'h00 || alu_b !== 8'h00 || alu_op !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ready=%b done=%b ill=%b res=%h z=%b a=%h b=%h op=%0d expected 1,0,0,00,0,00,00,0",
               instr_ready, done, illegal, result, z_flag, alu_a, alu_b, alu_op);
    end
    check_regs("reset_rf");
    @(negedge clk);
    reset_n = 1'b1;
    tick;
  endtask

  task automatic test_li;
    run_instr("li_r0", 1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 8'h05, 1'b0);
    run_instr("li_r1", 1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 8'h03, 1'b0);
    check_regs("li_rf");
  endtask

  task automatic test_add;
    run_instr("add_r2", 1'b0, 3'd0, 2'd2, 2'd0, 2'd1, 8'h00, 1'b0);
    n_tests++;
    if (m_rf[2] !== 8'h08 || z_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL add_value: got r2=%h z=%b expected 08 0", dbg_data, z_flag);
    end
  endtask

  task automatic test_wrap;
    run_instr("li_ff", 1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 8'hFF, 1'b0);
    run_instr("li_01", 1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 8'h01, 1'b0);
    run_instr("add_wrap", 1'b0, 3'd0, 2'd3, 2'd0, 2'd1, 8'h00, 1'b0);
    n_tests++;
    if (z_flag !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_z: got %b expected 1", z_flag);
    end
    run_instr("sub_wrap", 1'b0, 3'd1, 2'd3, 2'd1, 2'd0, 8'h00, 1'b0);
    check_regs("wrap_rf");
  endtask

  task automatic test_chain;
    run_instr("xor_self", 1'b0, 3'd4, 2'd1, 2'd1, 2'd1, 8'h00, 1'b0);
    run_instr("or_dep", 1'b0, 3'd3, 2'd2, 2'd1, 2'd1, 8'h00, 1'b0);
    check_regs("chain_rf");
  endtask

  task automatic test_illegal;
    run_instr("illegal_110", 1'b0, 3'd6, 2'd0, 2'd3, 2'd3, 8'h00, 1'b0);
    run_instr("illegal_111", 1'b0, 3'd7, 2'd3, 2'd0, 2'd1, 8'h00, 1'b0);
    check_regs("illegal_rf");
  endtask

  task automatic test_back_to_back;
    run_instr("hold_add", 1'b0, 3'd0, 2'd2, 2'd0, 2'd0, 8'h00, 1'b1);
    tick;
    n_tests++;
    if (done !== 1'b0 || instr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL no_double_accept: got done=%b ready=%b expected 0 1", done, instr_ready);
    end
    run_instr("hold_li", 1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 8'h00, 1'b1);
    run_instr("dep_not", 1'b0, 3'd5, 2'd3, 2'd1, 2'd2, 8'h00, 1'b1);
    check_regs("b2b_rf");
  endtask

  task automatic test_reset_mid;
    instr_valid = 1'b1; instr_li = 1'b0; instr_op = 3'd0;
    instr_rd = 2'd2; instr_rs = 2'd0; instr_rt = 2'd1;
    tick;
    #2;
    reset_n = 1'b0;
    #1;
    instr_valid = 1'b0;
    for (int i = 0; i < 4; i++) m_rf[i] = 8'h00;
    m_z = 1'b0;
    #3;
    reset_n = 1'b1;
    #1;
    n_tests++;
    if (instr_ready !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_release: got ready=%b done=%b expected 1 0", instr_ready, done);
    end
    tick;
    n_tests++;
    if (instr_ready !== 1'b1 || done !== 1'b0 || z_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_idle: got ready=%b done=%b z=%b expected 1 0 0",
               instr_ready, done, z_flag);
    end
    check_regs("reset_mid_rf");
  endtask

  task automatic test_random;
    for (int n = 0; n < 40; n++) begin
      run_instr("random", ($urandom_range(0, 9) < 3), 3'($urandom_range(0, 7)),
                2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
                bit'($urandom_range(0, 1)));
    end
    check_regs("random_rf");
  endtask

  initial begin
    test_reset;
    test_li;
    test_add;
    test_wrap;
    test_chain;
    test_illegal;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Operand-issue and write-back stage that sits directly upstream of the 8-bit ALU (ops 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 not a).
- Holds a small register file and accepts one instruction at a time over a valid/ready handshake.
- Drives the ALU operand and opcode inputs from registers, captures its combinational result and zero flag, then writes the result back.
- Provides load-immediate, illegal-opcode detection and a debug read port.

Parameters:
- DW, 8, datapath width; must equal the ALU operand width.
- RA_W, 2, register address width; the register file holds 2**RA_W entries of DW bits.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- instr_valid  in  1  instruction present.
- instr_ready  out  1  block can accept; high only in IDLE.
- instr_li  in  1  1 = load immediate, 0 = ALU operation.
- instr_op  in  3  ALU opcode (ignored when instr_li=1).
- instr_rd  in  RA_W  destination register.
- instr_rs  in  RA_W  source register for ALU input a.
- instr_rt  in  RA_W  source register for ALU input b.
- instr_imm  in  DW  immediate value for load immediate.
- alu_a  out  DW  ALU operand a (registered).
- alu_b  out  DW  ALU operand b (registered).
- alu_op  out  3  ALU opcode (registered).
- alu_res  in  DW  ALU result (combinational from alu_a/alu_b/alu_op).
- alu_z  in  1  ALU zero flag.
- done  out  1  one-cycle pulse in WB.
- illegal  out  1  valid only with done; 1 = opcode 110/111, write-back suppressed.
- result  out  DW  value written (or 0 when illegal); valid with done.
- z_flag  out  1  sticky zero flag of the last legal write-back.
- dbg_addr  in  RA_W  debug read address.
- dbg_data  out  DW  combinational read: rf[dbg_addr].

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state = IDLE.
  - All register-file entries = 0.
  - alu_a = alu_b = 0; alu_op = 000.
  - result = 0; z_flag = 0; done = 0; illegal = 0.
  - Reset mid-operation aborts the instruction: no write-back, no done.
- FSM states: IDLE, EXEC, WB.
- IDLE:
  - instr_ready = 1.
  - Acceptance occurs on a rising edge with instr_valid=1.
  - ALU operation with op <= 101: at the accept edge, latch alu_a = rf[rs], alu_b = rf[rt], alu_op = op and rd; go to EXEC.
  - instr_li=1: latch result = imm and rd; go to WB.
  - ALU operation with op 110/111: set the illegal latch; go to WB.
  - instr_valid=0: stay in IDLE; outputs hold.
- EXEC (1 cycle):
  - instr_ready = 0.
  - alu_a/alu_b/alu_op are stable for the whole cycle.
  - At the edge ending EXEC, capture result = alu_res and a pending z = alu_z; go to WB.
- WB (1 cycle):
  - done = 1; instr_ready = 0.
  - At the edge ending WB, if not illegal: rf[rd] = result and z_flag = pending z; go to IDLE.
  - For load immediate, pending z = (imm == 0).
  - Illegal: no register write, z_flag unchanged, result = 0.
- Latency and throughput:
  - ALU operation: accept edge to write-back edge = 2 cycles; 3 cycles per instruction.
  - Load immediate or illegal: 1 cycle to write-back; 2 cycles per instruction.
- Hazards:
  - Operands are read at the accept edge.
  - The previous write-back always completes before IDLE, so back-to-back dependent instructions see updated values; no forwarding is needed.
  - rd equal to rs or rt is legal; the old value is used as the operand.
- instr_valid while not ready: ignored; the upstream must hold the instruction until it sees instr_ready.
- Arithmetic: wrap-around (carry/borrow discarded) is performed by the ALU; this block passes DW bits unchanged.
- dbg_data:
  - Reads the current register contents.
  - A write in WB becomes visible the cycle after the WB edge.

Test Plan:
- Reset, then LI r0=8'h05, LI r1=8'h03 -> done pulses; dbg r0=05, r1=03; z_flag=0; each takes 2 cycles, instr_ready low 1 cycle.
- ADD r2=r0+r1 -> alu_a=05, alu_b=03, alu_op=000 during EXEC; done with result=08; r2=08 after WB; z_flag=0.
- LI r0=8'hFF, LI r1=8'h01, ADD r3=r0+r1 -> result=00 (wrap); z_flag=1. Then SUB r3=r1-r0 -> result=02; z_flag=0.
- Dependent chain XOR r1=r1^r1 then OR r2=r1|r1 -> r1=00 written before the OR is accepted; OR result=00; z_flag=1.
- Opcode 110 with z_flag=1 -> done=1, illegal=1, result=00; no register changes; z_flag stays 1; 2-cycle occupancy.
- Assert reset_n=0 during EXEC of ADD r2 -> no done; all registers read 0; instr_ready=1 immediately after release; instr_valid held during EXEC/WB is not accepted twice.
